// File: rtl/wayfarer_pkg.sv
// Purpose : shared types and default sizing for the destination picker and the PRNG it drives.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum and the default RAND_W / NUM_DEST constants, which the PRNG
//           instantiation reuses so both blocks agree on index width and destination count.
package wayfarer_pkg;

  localparam int DEF_RAND_W   = 4;
  localparam int DEF_NUM_DEST = 12;
  localparam int STAT_W       = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_RESP = 3'd2,
    FALLBACK  = 3'd3,
    HOLD      = 3'd4
  } pick_state_e;

endpackage

// File: rtl/rr_pointer.sv
// Purpose : modulo-N round-robin pointer; offers the current value, or the one after it when
//           the current value equals skip_i.
// Latency : pick_o is combinational from the pointer and skip_i; advance takes effect next cycle.
// Backpressure: none; the pointer only moves when adv_i is pulsed.
// Ports   : clk, reset (sync, active-high) | adv_i: step past the value on pick_o |
//           skip_i: value that must not be offered | pick_o: value to issue.
module rr_pointer #(
  parameter int W = 4,
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv_i,
  input  logic [W-1:0] skip_i,
  output logic [W-1:0] pick_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] rr_q, rr_d;
  logic [W-1:0] rr_inc;
  logic [W-1:0] pick_inc;

  always_comb begin
    rr_inc = (rr_q == LAST) ? '0 : rr_q + W'(1);
    // With N >= 2 the skipped-to value can never collide with skip_i again.
    pick_o = (rr_q == skip_i) ? rr_inc : rr_q;
    pick_inc = (pick_o == LAST) ? '0 : pick_o + W'(1);
    rr_d = adv_i ? pick_inc : rr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/random_dest_picker.sv
// Purpose : turns PRNG numbers into a legal destination (< NUM_DEST, != own_id), with a
//           round-robin fallback after MAX_RETRY failed attempts.
// Latency : best case 4 cycles from pick_req to dest_valid; worst case bounded by
//           MAX_RETRY * (RESP_TIMEOUT + 1) + 3 cycles.
// Backpressure: dest/dest_fallback held stable with dest_valid until dest_ready; no PRNG
//           requests are issued while holding.
// Ports   : clk, reset (sync, active-high) | pick_req, own_id: start a pick |
//           prng_next/prng_exclude/prng_valid/prng_number: PRNG handshake |
//           dest_valid/dest_ready/dest/dest_fallback: result handshake.
// Option  : define RANDOM_DEST_PICKER_STATS_EN to add saturating stat_attempts/stat_fallbacks.
module random_dest_picker
  import wayfarer_pkg::*;
#(
  parameter int RAND_W       = DEF_RAND_W,
  parameter int NUM_DEST     = DEF_NUM_DEST,
  parameter int MAX_RETRY    = 4,
  parameter int RESP_TIMEOUT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pick_req,
  input  logic [RAND_W-1:0] own_id,
  output logic              prng_next,
  output logic [RAND_W-1:0] prng_exclude,
  input  logic              prng_valid,
  input  logic [RAND_W-1:0] prng_number,
  output logic              dest_valid,
  input  logic              dest_ready,
  output logic [RAND_W-1:0] dest,
  output logic              dest_fallback
`ifdef RANDOM_DEST_PICKER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_attempts,
  output logic [STAT_W-1:0] stat_fallbacks
`endif
);

  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int TMO_W = $clog2(RESP_TIMEOUT);
  // One extra bit so NUM_DEST == 2**RAND_W is representable in the range check.
  localparam logic [RAND_W:0]  NUM_DEST_X = (RAND_W + 1)'(NUM_DEST);
  localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(RESP_TIMEOUT - 1);

  pick_state_e       state_q, state_d;
  logic [RAND_W-1:0] own_q, own_d;
  logic [RAND_W-1:0] dest_q, dest_d;
  logic              fb_q, fb_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RTY_W-1:0]  retry_inc;
  logic              num_ok;
  logic              attempt_fail;
  logic              rr_adv;
  logic [RAND_W-1:0] rr_pick;

  rr_pointer #(
    .W (RAND_W),
    .N (NUM_DEST)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .adv_i  (rr_adv),
    .skip_i (own_q),
    .pick_o (rr_pick)
  );

  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    dest_d       = dest_q;
    fb_d         = fb_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    attempt_fail = 1'b0;
    rr_adv       = 1'b0;
    prng_next    = 1'b0;
    retry_inc    = retry_q + RTY_W'(1);
    // Out-of-range values are rejected outright, never folded into range.
    num_ok       = ({1'b0, prng_number} < NUM_DEST_X) && (prng_number != own_q);

    case (state_q)
      IDLE: begin
        if (pick_req) begin
          own_d   = own_id;
          retry_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        prng_next = 1'b1;
        tmo_d     = '0;
        state_d   = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (prng_valid) begin
          if (num_ok) begin
            dest_d  = prng_number;
            fb_d    = 1'b0;
            state_d = HOLD;
          end else begin
            attempt_fail = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (attempt_fail) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RTY_LAST) ? FALLBACK : REQ;
        end
      end
      FALLBACK: begin
        dest_d  = rr_pick;
        fb_d    = 1'b1;
        rr_adv  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (dest_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      own_q   <= '0;
      dest_q  <= '0;
      fb_q    <= 1'b0;
      retry_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      dest_q  <= dest_d;
      fb_q    <= fb_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dest_valid    = (state_q == HOLD);
  assign dest          = dest_q;
  assign dest_fallback = fb_q;
  assign prng_exclude  = own_q;

`ifdef RANDOM_DEST_PICKER_STATS_EN
  logic [STAT_W-1:0] att_q, fbk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      att_q <= '0;
      fbk_q <= '0;
    end else begin
      if ((state_q == REQ) && (att_q != {STAT_W{1'b1}})) begin
        att_q <= att_q + STAT_W'(1);
      end
      if ((state_q == FALLBACK) && (fbk_q != {STAT_W{1'b1}})) begin
        fbk_q <= fbk_q + STAT_W'(1);
      end
    end
  end

  assign stat_attempts  = att_q;
  assign stat_fallbacks = fbk_q;
`endif

endmodule

// File: tb/tb_random_dest_picker.sv
// Purpose : directed self-checking bench for random_dest_picker (NUM_DEST=12, RAND_W=4).
// Latency : PRNG model answers two cycles after each prng_next when it has a value queued.
// Backpressure: dest_ready is driven low by default and pulsed to accept a destination.
module tb_random_dest_picker;
  import wayfarer_pkg::*;

  logic       clk;
  logic       reset;
  logic       pick_req;
  logic [3:0] own_id;
  logic       prng_next;
  logic [3:0] prng_exclude;
  logic       prng_valid;
  logic [3:0] prng_number;
  logic       dest_valid;
  logic       dest_ready;
  logic [3:0] dest;
  logic       dest_fallback;
`ifdef RANDOM_DEST_PICKER_STATS_EN
  logic [15:0] stat_attempts;
  logic [15:0] stat_fallbacks;
`endif

  random_dest_picker #(
    .RAND_W       (4),
    .NUM_DEST     (12),
    .MAX_RETRY    (4),
    .RESP_TIMEOUT (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pick_req      (pick_req),
    .own_id        (own_id),
    .prng_next     (prng_next),
    .prng_exclude  (prng_exclude),
    .prng_valid    (prng_valid),
    .prng_number   (prng_number),
    .dest_valid    (dest_valid),
    .dest_ready    (dest_ready),
    .dest          (dest),
    .dest_fallback (dest_fallback)
`ifdef RANDOM_DEST_PICKER_STATS_EN
    ,
    .stat_attempts  (stat_attempts),
    .stat_fallbacks (stat_fallbacks)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [3:0] rq[$];
  logic       toggle_mode = 1'b0;
  int         npulse;
  int         pulse_cyc[8];
  int         lat;
  logic       got;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // PRNG model, acting on the falling edge so it never races the main thread.
  initial begin
    int         pend_at;
    logic       pend;
    logic [3:0] pend_val;
    pend        = 1'b0;
    pend_at     = 0;
    pend_val    = '0;
    prng_valid  = 1'b0;
    prng_number = '0;
    forever begin
      @(negedge clk);
      if (toggle_mode) begin
        prng_valid  = ~prng_valid;
        prng_number = 4'(cyc);
      end else begin
        prng_valid = 1'b0;
        if (pend && (cyc == pend_at)) begin
          prng_valid  = 1'b1;
          prng_number = pend_val;
          pend        = 1'b0;
        end
        if (prng_next && (rq.size() > 0)) begin
          pend_val = rq.pop_front();
          pend     = 1'b1;
          pend_at  = cyc + 2;
        end
      end
    end
  end

  // Starts a pick in the current cycle and runs until dest_valid or the budget expires.
  task automatic run_pick(input logic [3:0] id, input int budget);
    int start;
    own_id   = id;
    pick_req = 1'b1;
    start    = cyc;
    step();
    pick_req = 1'b0;
    npulse   = 0;
    got      = 1'b0;
    for (int i = 0; i < 8; i++) pulse_cyc[i] = 0;
    for (int i = 0; i < budget && !got; i++) begin
      if (prng_next) begin
        if (npulse < 8) pulse_cyc[npulse] = cyc;
        npulse++;
      end
      if (dest_valid) got = 1'b1;
      else step();
    end
    lat = cyc - start;
    chk("pick_done", 32'(got), 32'(1));
  endtask

  task automatic accept();
    dest_ready = 1'b1;
    step();
    dest_ready = 1'b0;
    chk("accept_drop", 32'(dest_valid), 32'(0));
  endtask

  initial begin
    reset      = 1'b1;
    pick_req   = 1'b0;
    own_id     = '0;
    dest_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_next",     32'(prng_next),     32'(0));
    chk("rst_valid",    32'(dest_valid),    32'(0));
    chk("rst_dest",     32'(dest),          32'(0));
    chk("rst_fb",       32'(dest_fallback), 32'(0));
    chk("rst_excl",     32'(prng_exclude),  32'(0));

    // Valid on first try: 7 with own_id 3.
    rq.push_back(4'd7);
    run_pick(4'd3, 20);
    chk("t1_lat",    32'(lat),           32'(4));
    chk("t1_pulses", 32'(npulse),        32'(1));
    chk("t1_dest",   32'(dest),          32'(7));
    chk("t1_fb",     32'(dest_fallback), 32'(0));
    chk("t1_excl",   32'(prng_exclude),  32'(3));

    // Backpressure: held for 10 cycles with PRNG activity that must be ignored.
    toggle_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(dest_valid),    32'(1));
      chk("bp_dest",  32'(dest),          32'(7));
      chk("bp_fb",    32'(dest_fallback), 32'(0));
      chk("bp_next",  32'(prng_next),     32'(0));
    end
    toggle_mode = 1'b0;

    // Handoff with pick_req already high: not taken in the handoff cycle.
    rq.push_back(4'd13);
    rq.push_back(4'd14);
    rq.push_back(4'd5);
    own_id     = 4'd3;
    pick_req   = 1'b1;
    dest_ready = 1'b1;
    step();
    dest_ready = 1'b0;
    chk("b2b_valid_drop", 32'(dest_valid), 32'(0));
    chk("b2b_no_req",     32'(prng_next),  32'(0));

    // Out-of-range rejection: 13, 14, then 5 (pick_req still high in IDLE).
    run_pick(4'd3, 40);
    chk("t2_pulses", 32'(npulse),        32'(3));
    chk("t2_dest",   32'(dest),          32'(5));
    chk("t2_fb",     32'(dest_fallback), 32'(0));
    accept();

    // Reset while waiting for a PRNG response.
    own_id   = 4'd5;
    pick_req = 1'b1;
    step();
    pick_req = 1'b0;
    chk("rm_req", 32'(prng_next), 32'(1));
    step();
    chk("rm_wait", 32'(dut.state_q), 32'(WAIT_RESP));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_next",  32'(prng_next),     32'(0));
    chk("rm_valid", 32'(dest_valid),    32'(0));
    chk("rm_dest",  32'(dest),          32'(0));
    chk("rm_excl",  32'(prng_exclude),  32'(0));
    chk("rm_state", 32'(dut.state_q),   32'(IDLE));
    step();
    chk("rm_idle_next", 32'(prng_next), 32'(0));

    rq.push_back(4'd9);
    run_pick(4'd5, 20);
    chk("rm2_lat",  32'(lat),           32'(4));
    chk("rm2_dest", 32'(dest),          32'(9));
    chk("rm2_fb",   32'(dest_fallback), 32'(0));
    chk("rm2_excl", 32'(prng_exclude),  32'(5));
    accept();

    // Fresh reset so rr and statistics start from zero; then fallback twice.
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef RANDOM_DEST_PICKER_STATS_EN
    chk("st_att0", 32'(stat_attempts),  32'(0));
    chk("st_fb0",  32'(stat_fallbacks), 32'(0));
`endif
    run_pick(4'd0, 60);
    chk("fb1_pulses", 32'(npulse),        32'(4));
    for (int i = 1; i < 4; i++) begin
      chk("fb1_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(4));
    end
    chk("fb1_lat",  32'(lat),           32'(18));
    chk("fb1_dest", 32'(dest),          32'(1));
    chk("fb1_fb",   32'(dest_fallback), 32'(1));
    accept();

    run_pick(4'd0, 60);
    chk("fb2_pulses", 32'(npulse),        32'(4));
    chk("fb2_dest",   32'(dest),          32'(2));
    chk("fb2_fb",     32'(dest_fallback), 32'(1));
    accept();
`ifdef RANDOM_DEST_PICKER_STATS_EN
    chk("st_att", 32'(stat_attempts),  32'(8));
    chk("st_fb",  32'(stat_fallbacks), 32'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/random_dest_picker.md
Name: random_dest_picker

Overview:
- Sits directly downstream of the PRNG block and drives its request/exclude inputs.
- On each downstream request, turns raw random numbers into one legal destination index:
  - in range 0..NUM_DEST-1
  - never equal to own_id
- Retries bounded by MAX_RETRY; on exhaustion falls back to a deterministic round-robin pick.
- Result is held on a valid/ready interface for the packet-injection logic.

Parameters:
- RAND_W, 4, width of PRNG output and of destination index.
- NUM_DEST, 12, number of legal destinations; 2 <= NUM_DEST <= 2**RAND_W.
- MAX_RETRY, 4, PRNG attempts per pick before fallback; >= 1.
- RESP_TIMEOUT, 3, cycles to wait for prng_valid per attempt; >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pick_req  in  1  pulse/level: start a pick; sampled only in IDLE
- own_id  in  RAND_W  index to exclude; sampled at pick start
- prng_next  out  1  request to PRNG
- prng_exclude  out  RAND_W  exclude value to PRNG (= latched own_id)
- prng_valid  in  1  PRNG number valid, non-clashing
- prng_number  in  RAND_W  PRNG output
- dest_valid  out  1  destination available
- dest_ready  in  1  consumer accepts destination
- dest  out  RAND_W  chosen destination
- dest_fallback  out  1  qualifies dest: 1 = came from round-robin fallback

Behaviour:
- One clock `clk`. Reset is synchronous and active-high.
- Reset values:
  - prng_next=0, dest_valid=0, dest=0, dest_fallback=0, prng_exclude=0
  - retry counter=0, timeout counter=0
  - round-robin pointer rr=0, state=IDLE
- FSM states:
  - IDLE:
    - if pick_req: latch own_id, clear retry counter, go to REQ.
  - REQ:
    - prng_next=1 for exactly this cycle; clear timeout counter; go to WAIT_RESP.
  - WAIT_RESP:
    - prng_valid=1 and prng_number<NUM_DEST and prng_number!=own_id: dest<=prng_number, dest_fallback<=0, go to HOLD.
    - prng_valid=1 but value rejected (out of range or equals own_id): count as failed attempt.
    - timeout counter reaching RESP_TIMEOUT-1 without prng_valid: count as failed attempt.
    - Failed attempt: retry+1. If retry+1==MAX_RETRY go to FALLBACK, else go to REQ.
    - prng_valid is ignored in every state except WAIT_RESP.
  - FALLBACK:
    - dest<=rr, or (rr+1) mod NUM_DEST if rr==own_id.
    - dest_fallback<=1.
    - rr advances past the issued value, mod NUM_DEST.
    - go to HOLD.
  - HOLD:
    - dest_valid=1; dest and dest_fallback stable.
    - on dest_valid&dest_ready go to IDLE; dest_valid drops the next cycle.
- Latency, best case: pick_req at cycle 0 -> REQ at cycle 1 -> earliest prng_valid at cycle 3 -> dest_valid at cycle 4.
- Back-to-back:
  - pick_req asserted in the cycle HOLD hands off is not accepted.
  - pick_req is accepted the next cycle, in IDLE.
- Arithmetic and widths:
  - Comparisons are unsigned at RAND_W.
  - rr wraps NUM_DEST-1 -> 0.
  - No modulo folding of PRNG values: out-of-range values are always rejected.
- own_id >= NUM_DEST: every attempt is evaluated normally; fallback never needs to skip.
- Reset mid-operation: any state returns to IDLE next cycle; all outputs take reset values; a pending pick is dropped.
- pick_req held high continuously: one pick per IDLE visit.

Optional Feature:
- Macro: RANDOM_DEST_PICKER_STATS_EN.
- Defined:
  - adds outputs stat_attempts[15:0] (total PRNG requests issued) and stat_fallbacks[15:0] (total FALLBACK entries).
  - both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package `wayfarer_pkg`:
  - FSM state enum (IDLE, REQ, WAIT_RESP, FALLBACK, HOLD).
  - Default RAND_W/NUM_DEST constants reused by the PRNG instantiation.
- One natural sub-module: `rr_pointer`, the modulo-NUM_DEST round-robin counter with skip-one output.
- The rest stays flat in random_dest_picker.

Test Plan:
- Valid first try: NUM_DEST=12, own_id=3, PRNG model returns valid with 7 two cycles after prng_next.
  - Required: dest=7, dest_fallback=0, dest_valid at cycle 4.
  - Required: dest_valid held until dest_ready, then IDLE.
- Out-of-range rejection: PRNG returns 13, then 14, then 5.
  - Required: three prng_next pulses, dest=5, dest_fallback=0.
- Fallback with skip: no prng_valid ever, own_id=0, rr=0.
  - Required: four prng_next pulses each spaced RESP_TIMEOUT+1 cycles.
  - Required: dest=1, dest_fallback=1; next fallback gives dest=2.
- Backpressure: dest_ready low for 10 cycles while PRNG toggles valid/number.
  - Required: dest, dest_valid, dest_fallback unchanged; no prng_next.
- Reset mid-operation: assert reset during WAIT_RESP.
  - Required: next cycle prng_next=0, dest_valid=0, dest=0, state IDLE.
  - Required: a new pick_req works normally.
- Stats build (RANDOM_DEST_PICKER_STATS_EN): run the fallback scenario twice.
  - Required: stat_attempts=8, stat_fallbacks=2.
